recon_arbiter: RTL and testbench
================================

Name: recon_arbiter

Overview:
- Shares one Reconstruct engine among NUM_REQ mode pickers: luma i16 picker, luma i4 picker and chroma UV picker.
- Performs round-robin arbitration and muxes the granted requester's prediction block onto the engine input.
- Issues a one-cycle engine start, waits for engine done, then returns a per-requester done pulse.
- Sits between the pickers and the single Reconstruct/GetSSE/Disto/GetCostLuma datapath instance, so that datapath is not replicated per picker.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- PRED_W, 2048, width of one prediction block (8 bits x 16 x 16).
- TIMEOUT, 4096, watchdog limit in cycles. Used only with RECON_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester job request, level.
- req_pred  in  NUM_REQ*PRED_W  prediction blocks; requester i occupies slice [i*PRED_W +: PRED_W].
- gnt  out  NUM_REQ  one-hot grant, registered.
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  NUM_REQ  one-cycle timeout pulse. Driven 0 when the feature is off.
- eng_start  out  1  one-cycle start to the engine.
- eng_pred  out  PRED_W  registered prediction block to the engine (YPred).
- eng_done  in  1  engine completion pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer ptr=0, sel=0.
- State IDLE:
  - If req is nonzero, pick the first set bit scanning ptr, ptr+1, ... modulo NUM_REQ.
  - Register sel and gnt=onehot(sel), latch eng_pred=req_pred[sel], go to ISSUE.
  - If req is zero, stay in IDLE.
- State ISSUE:
  - eng_start=1 for exactly this cycle.
  - Go to RUN.
- State RUN:
  - eng_start=0.
  - When eng_done is sampled high, go to RELEASE.
  - eng_done is ignored in every state other than RUN.
- State RELEASE:
  - rsp_done[sel]=1 for this cycle only; the cycle counter resets here.
  - gnt is cleared at the exit edge.
  - ptr <= (sel+1) mod NUM_REQ, then go to IDLE.
- Latency:
  - req sampled at edge k gives gnt and eng_start high in cycle k+1.
  - eng_done sampled at edge m gives rsp_done in cycle m+1.
  - Minimum gap between consecutive eng_start pulses is 3 cycles plus engine latency.
- Request rules:
  - Requesters hold req until they see their rsp_done.
  - Deasserting req before grant withdraws the request.
  - Deasserting req after grant has no effect; the job completes and rsp_done still pulses.
  - A requester must drop req in the cycle after rsp_done, or it is eligible again, but at lowest priority.
- eng_pred stays stable from grant until the next grant. Engine outputs are valid for the requester from rsp_done until the next eng_start.
- gnt is never more than one-hot. gnt, busy and state are consistent every cycle.
- Simultaneous requests: the round-robin rule guarantees no requester waits more than NUM_REQ-1 jobs.
- Reset mid-operation:
  - Returns to IDLE immediately with all outputs 0.
  - Any in-flight engine job is discarded; an eng_done arriving afterwards is ignored.

Optional Feature:
- Macro RECON_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit cycle counter runs in RUN.
  - If it reaches TIMEOUT with no eng_done, rsp_err[sel] and rsp_done[sel] pulse together in RELEASE, and the grant is released normally.
  - An eng_done arriving in the same cycle the counter reaches TIMEOUT takes precedence; no error is raised.
- When undefined: no counter, rsp_err is tied to 0, and RUN waits indefinitely.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1, ISSUE=2, RUN=4, RELEASE=8 (one-hot);
  - default PRED_W;
  - requester index constants REQ_I16=0, REQ_I4=1, REQ_UV=2.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs req and ptr and outputs idx and valid. It is reused by other shared-resource arbiters.

Test Plan:
- Single requester: req=3'b001, pred0=all 0x80, engine done after 20 cycles.
  - Expect gnt=001 and eng_start the cycle after req.
  - Expect eng_pred=all 0x80.
  - Expect rsp_done[0] one cycle after eng_done, and busy low 2 cycles later.
- Contention: req=3'b111 held, with requesters deasserting after their own rsp_done.
  - Grant order is 0, 1, 2.
  - Then re-raise req=3'b101; order is 0, 2.
- Withdrawal: req[1] high one cycle while a job is busy on 0, then low.
  - Requester 1 is never granted.
  - Next grant goes to the next pending requester, or the arbiter stays IDLE.
- Spurious done: pulse eng_done in IDLE and in ISSUE.
  - No rsp_done occurs and state is unaffected.
- Reset mid-RUN: assert rst_n low during RUN.
  - All outputs are 0 and ptr=0.
  - A later eng_done produces nothing.
- Timeout (macro on, TIMEOUT=16): grant 2 with eng_done never asserted.
  - rsp_err[2] and rsp_done[2] pulse in the same cycle, 16 cycles after RUN entry.
  - Next grant then proceeds from ptr=0.

Source files
------------

// File: rtl/recon_arbiter_pkg.sv
// Shared definitions for the Reconstruct-engine arbiter: state encoding,
// default block width and requester indices.
package recon_arbiter_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_ISSUE   = 4'b0010,
      ST_RUN     = 4'b0100,
      ST_RELEASE = 4'b1000
   } state_t;

   localparam int PRED_W_DEFAULT  = 2048;
   localparam int NUM_REQ_DEFAULT = 3;

   localparam int REQ_I16 = 0;
   localparam int REQ_I4  = 1;
   localparam int REQ_UV  = 2;

endpackage

// File: rtl/recon_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// found scanning ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
   import recon_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   logic [NUM_REQ-1:0] rot;
   logic [NUM_REQ-1:0] hit;
   logic [IDX_W-1:0]   acc [NUM_REQ+1];

   // Rotate so that bit 0 of rot is the requester currently holding priority.
   assign rot    = NUM_REQ'({req, req} >> ptr);
   assign acc[0] = '0;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         logic [IDX_W:0]   sum;
         logic [IDX_W-1:0] wrap;

         if (gi == 0) begin : g_first
            assign hit[gi] = rot[gi];
         end else begin : g_rest
            assign hit[gi] = rot[gi] & ~(|rot[gi-1:0]);
         end

         assign sum  = {1'b0, ptr} + (IDX_W+1)'(gi);
         assign wrap = IDX_W'((sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum);
         assign acc[gi+1] = acc[gi] | (hit[gi] ? wrap : '0);
      end
   endgenerate

   assign idx   = acc[NUM_REQ];
   assign valid = |req;

endmodule

// File: rtl/recon_arbiter.sv
// Round-robin arbiter sharing one Reconstruct engine among the mode pickers.
// Optional watchdog enabled by defining RECON_ARB_TIMEOUT_EN.
module recon_arbiter
   import recon_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int PRED_W  = PRED_W_DEFAULT,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*PRED_W-1:0] req_pred,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_done,
   output logic [NUM_REQ-1:0]        rsp_err,
   output logic                      eng_start,
   output logic [PRED_W-1:0]         eng_pred,
   input  logic                      eng_done,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   generate
      if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT < 1)) begin : g_param_check
         $fatal(1, "recon_arbiter: illegal NUM_REQ or TIMEOUT");
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   sel_reg, ptr_reg, pick_idx;
   logic               pick_valid;
   logic [NUM_REQ-1:0] gnt_reg, pick_onehot;
   logic [PRED_W-1:0]  pred_reg;
   logic               timeout_hit;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
      end
   endgenerate

`ifdef RECON_ARB_TIMEOUT_EN
   logic [31:0] cnt_reg;
   logic        err_reg;

   // eng_done wins over a simultaneous expiry, so no error is flagged then.
   assign timeout_hit = (state_reg == ST_RUN) && !eng_done &&
                        ((cnt_reg + 32'd1) == 32'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else if (state_reg == ST_RUN) begin
         cnt_reg <= cnt_reg + 32'd1;
         err_reg <= timeout_hit;
      end else if (state_reg == ST_RELEASE) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:    if (pick_valid) state_next = ST_ISSUE;
         ST_ISSUE:   state_next = ST_RUN;
         ST_RUN:     if (eng_done || timeout_hit) state_next = ST_RELEASE;
         ST_RELEASE: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_reg  <= '0;
         ptr_reg  <= '0;
         gnt_reg  <= '0;
         pred_reg <= '0;
      end else if (state_reg == ST_IDLE && pick_valid) begin
         sel_reg  <= pick_idx;
         gnt_reg  <= pick_onehot;
         pred_reg <= req_pred[pick_idx*PRED_W +: PRED_W];
      end else if (state_reg == ST_RELEASE) begin
         gnt_reg <= '0;
         ptr_reg <= (sel_reg == IDX_W'(NUM_REQ-1)) ? '0 : sel_reg + IDX_W'(1);
      end
   end

   always_comb begin
      eng_start = (state_reg == ST_ISSUE);
      busy      = (state_reg != ST_IDLE);
      rsp_done  = (state_reg == ST_RELEASE) ? gnt_reg : '0;
`ifdef RECON_ARB_TIMEOUT_EN
      rsp_err   = (state_reg == ST_RELEASE && err_reg) ? gnt_reg : '0;
`else
      rsp_err   = '0;
`endif
   end

   assign gnt      = gnt_reg;
   assign eng_pred = pred_reg;

endmodule

// File: tb/tb_recon_arbiter.sv
// Directed bench for recon_arbiter with a queue of expected grant indices.
// Define RECON_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=16).
module tb_recon_arbiter;

   localparam int N  = 3;
   localparam int PW = 2048;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*PW-1:0] req_pred;
   logic [N-1:0]    gnt, rsp_done, rsp_err;
   logic            eng_start, eng_done, busy;
   logic [PW-1:0]   eng_pred;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   logic [7:0] pat [N] = '{8'h80, 8'h41, 8'hC3};

   always #5 clk = ~clk;

   recon_arbiter #(.NUM_REQ(N), .PRED_W(PW), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_pred  (req_pred),
      .gnt       (gnt),
      .rsp_done  (rsp_done),
      .rsp_err   (rsp_err),
      .eng_start (eng_start),
      .eng_pred  (eng_pred),
      .eng_done  (eng_done),
      .busy      (busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input int i);
      return 32'd1 << i;
   endfunction

   function automatic logic [PW-1:0] fill(input logic [7:0] b);
      return {(PW/8){b}};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pred(input string tag, input logic [PW-1:0] exp);
      n_checks++;
      assert (eng_pred === exp) else begin
         n_fail++;
         $error("FAIL %s observed[31:0]=%0h expected[31:0]=%0h", tag, eng_pred[31:0], exp[31:0]);
      end
   endtask

   // Serve one granted job: check grant/pred, run the engine for lat cycles,
   // then check the completion pulse and release.
   task automatic serve(input int lat, input bit spurious, input logic [N-1:0] poke);
      int n = 0;
      int idx = 0;
      while (eng_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("start_seen", 32'(eng_start), 32'd1);
      if (exp_q.size() > 0) idx = exp_q.pop_front();
      chk("gnt", 32'(gnt), onehot(idx));
      chk_pred("eng_pred", fill(pat[idx]));
      chk("busy_issue", 32'(busy), 32'd1);
      if (spurious) eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("start_one_cycle", 32'(eng_start), 32'd0);
      chk("no_done_run", 32'(rsp_done), 32'd0);
      for (int i = 0; i < lat; i++) begin
         if (i == 0) req = req | poke;
         if (i == 1) req = req & ~poke;
         tick();
      end
      chk("no_early_done", 32'(rsp_done), 32'd0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("rsp_done", 32'(rsp_done), onehot(idx));
      chk("rsp_err", 32'(rsp_err), 32'd0);
      req = req & ~N'(onehot(idx));
      $display("job: requester %0d served, engine latency %0d", idx, lat);
      tick();
      chk("busy_after", 32'(busy), 32'd0);
      chk("gnt_cleared", 32'(gnt), 32'd0);
      chk("done_one_cycle", 32'(rsp_done), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = '0;
      eng_done = 1'b0;
      for (int i = 0; i < N; i++) req_pred[i*PW +: PW] = fill(pat[i]);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(eng_start), 32'd0);
      chk("rst_done", 32'(rsp_done), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk_pred("rst_pred", '0);
      rst_n = 1'b1;
      tick();

      // Spurious done while idle
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("idle_spur_done", 32'(rsp_done), 32'd0);
      chk("idle_spur_busy", 32'(busy), 32'd0);
      tick();
      chk("idle_spur_done2", 32'(rsp_done), 32'd0);

      // Single requester, spurious done during ISSUE, engine latency 20
      req = 3'b001;
      exp_q.push_back(0);
      tick();
      chk("start_latency", 32'(eng_start), 32'd1);
      serve(20, 1'b1, '0);

      // Withdrawal: requester 1 pulses req for one cycle during a busy job
      req = 3'b001;
      exp_q.push_back(0);
      tick();
      serve(5, 1'b0, 3'b010);
      repeat (3) tick();
      chk("withdraw_idle_busy", 32'(busy), 32'd0);
      chk("withdraw_idle_gnt", 32'(gnt), 32'd0);

      // Reset mid-RUN (ptr is 1 here, so requester 1 wins)
      req = 3'b010;
      tick();
      chk("mid_gnt", 32'(gnt), 32'd2);
      chk("mid_start", 32'(eng_start), 32'd1);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_start", 32'(eng_start), 32'd0);
      chk_pred("mid_rst_pred", '0);
      req = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("late_done_rsp", 32'(rsp_done), 32'd0);
      chk("late_done_busy", 32'(busy), 32'd0);
      tick();
      chk("late_done_rsp2", 32'(rsp_done), 32'd0);

      // Contention from ptr=0: order 0,1,2 then 0,2
      req = 3'b111;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      serve(4, 1'b0, '0);
      serve(4, 1'b0, '0);
      serve(4, 1'b0, '0);
      chk("contention_req_dropped", 32'(req), 32'd0);
      req = 3'b101;
      exp_q.push_back(0);
      exp_q.push_back(2);
      serve(3, 1'b0, '0);
      serve(3, 1'b0, '0);

`ifdef RECON_ARB_TIMEOUT_EN
      // Watchdog: grant 2, engine never answers
      req = 3'b100;
      tick();
      chk("to_gnt", 32'(gnt), 32'd4);
      chk("to_start", 32'(eng_start), 32'd1);
      repeat (16) tick();
      chk("to_not_yet", 32'(rsp_done), 32'd0);
      tick();
      chk("to_rsp_done", 32'(rsp_done), 32'd4);
      chk("to_rsp_err", 32'(rsp_err), 32'd4);
      $display("job: requester 2 timed out");
      req = '0;
      tick();
      chk("to_busy_after", 32'(busy), 32'd0);
      chk("to_err_one_cycle", 32'(rsp_err), 32'd0);
      req = 3'b110;
      exp_q.push_back(1);
      tick();
      serve(2, 1'b0, '0);
      req = '0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
